divider: RTL and testbench



---
 rtl/divider.sv | 223 ++++++++++++++++++++++
 tb/tb_divider.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/divider.sv
// Sequential radix-2 restoring divider for RV32M div/divu/rem/remu. Signed operands are divided as magnitudes, then the signs are corrected.
// Latency: 33 cycles from the accept edge to the done pulse, or 1 cycle for divide-by-zero/overflow when DIV_FASTPATH_EN is defined.
// Backpressure: busy stays high in CALC and DONE, and start is only sampled in IDLE. flush aborts the operation from any state.

package m_extension;
    typedef enum logic [2:0] {
        F3_MUL    = 3'b000,
        F3_MULH   = 3'b001,
        F3_MULHSU = 3'b010,
        F3_MULHU  = 3'b011,
        F3_DIV    = 3'b100,
        F3_DIVU   = 3'b101,
        F3_REM    = 3'b110,
        F3_REMU   = 3'b111
    } m_funct3;
endpackage

module divider
    import m_extension::*;
#(
    parameter int XLEN = 32,    // only 32 is supported
    parameter int ITER = 32     // must equal XLEN
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  m_funct3         funct3,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] div_out
);

    localparam int              CW      = $clog2(ITER);
    localparam logic [CW-1:0]   LAST    = CW'(ITER - 1);
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Two's complement negate when requested. INT_MIN maps to itself, which is
    // the correct unsigned magnitude.
    function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] x,
                                                  input logic            neg);
        return neg ? (~x + XLEN'(1)) : x;
    endfunction

    // Architectural result. The RISC-V special cases take priority over the
    // sign-corrected quotient or remainder.
    function automatic logic [XLEN-1:0] final_result(
        input logic [XLEN-1:0] q,
        input logic [XLEN-1:0] r,
        input logic            is_signed,
        input logic            is_rem,
        input logic            qneg,
        input logic            rneg,
        input logic [XLEN-1:0] a,
        input logic [XLEN-1:0] b
    );
        logic div0;
        logic ovf;
        div0 = (b == '0);
        ovf  = is_signed && (a == INT_MIN) && (b == '1);
        if (div0)
            return is_rem ? a : '1;
        if (ovf)
            return is_rem ? '0 : INT_MIN;
        if (is_rem)
            return magnitude(r, rneg);
        return magnitude(q, qneg);
    endfunction

    state_t          state_q,     state_d;
    logic [CW-1:0]   cnt_q,       cnt_d;
    // Partial remainder. It always ends an iteration below the divisor, so
    // XLEN bits hold it. The shifted value R' (r_shift) is XLEN+1 bits wide.
    logic [XLEN-1:0] rem_acc_q,   rem_acc_d;
    // The dividend magnitude shifts out of the top while quotient bits shift in.
    logic [XLEN-1:0] quo_q,       quo_d;
    logic [XLEN-1:0] divisor_q,   divisor_d;
    logic            is_signed_q, is_signed_d;
    logic            is_rem_q,    is_rem_d;
    logic            qsign_q,     qsign_d;
    logic            rsign_q,     rsign_d;
    logic [XLEN-1:0] rs1_raw_q,   rs1_raw_d;
    logic [XLEN-1:0] rs2_raw_q,   rs2_raw_d;
    logic [XLEN-1:0] div_out_q,   div_out_d;

    // Decode of the request. All four divide opcodes have funct3[2] set.
    logic op_valid;
    logic op_signed;
    logic op_rem;
    logic accept;

    assign op_valid  = funct3[2];
    assign op_signed = ~funct3[0];
    assign op_rem    = funct3[1];
    assign accept    = (state_q == S_IDLE) && start && op_valid && !flush;

`ifdef DIV_FASTPATH_EN
    logic fast_special;
    assign fast_special = (rs2_data == '0) ||
                          (op_signed && (rs1_data == INT_MIN) && (rs2_data == '1));
`endif

    // One restoring step: shift in the next dividend bit, then subtract the
    // divisor if it fits.
    logic [XLEN:0]   r_shift;
    logic            r_ge;
    logic [XLEN-1:0] r_sub;
    logic [XLEN-1:0] rem_next;
    logic [XLEN-1:0] quo_next;

    assign r_shift  = {rem_acc_q, quo_q[XLEN-1]};
    assign r_ge     = (r_shift >= {1'b0, divisor_q});
    assign r_sub    = r_shift[XLEN-1:0] - divisor_q;
    assign rem_next = r_ge ? r_sub : r_shift[XLEN-1:0];
    assign quo_next = {quo_q[XLEN-2:0], r_ge};

    assign div_out  = div_out_q;

    // State and datapath registers. Reset clears everything and drops any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            rem_acc_q   <= '0;
            quo_q       <= '0;
            divisor_q   <= '0;
            is_signed_q <= 1'b0;
            is_rem_q    <= 1'b0;
            qsign_q     <= 1'b0;
            rsign_q     <= 1'b0;
            rs1_raw_q   <= '0;
            rs2_raw_q   <= '0;
            div_out_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_acc_q   <= rem_acc_d;
            quo_q       <= quo_d;
            divisor_q   <= divisor_d;
            is_signed_q <= is_signed_d;
            is_rem_q    <= is_rem_d;
            qsign_q     <= qsign_d;
            rsign_q     <= rsign_d;
            rs1_raw_q   <= rs1_raw_d;
            rs2_raw_q   <= rs2_raw_d;
            div_out_q   <= div_out_d;
        end
    end

    // Next-state, datapath update and status outputs. flush overrides everything else.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_acc_d   = rem_acc_q;
        quo_d       = quo_q;
        divisor_d   = divisor_q;
        is_signed_d = is_signed_q;
        is_rem_d    = is_rem_q;
        qsign_d     = qsign_q;
        rsign_d     = rsign_q;
        rs1_raw_d   = rs1_raw_q;
        rs2_raw_d   = rs2_raw_q;
        div_out_d   = div_out_q;
        busy        = (state_q != S_IDLE);
        done        = (state_q == S_DONE);

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    is_signed_d = op_signed;
                    is_rem_d    = op_rem;
                    qsign_d     = op_signed && (rs1_data[XLEN-1] ^ rs2_data[XLEN-1]);
                    rsign_d     = op_signed && rs1_data[XLEN-1];
                    quo_d       = magnitude(rs1_data, op_signed && rs1_data[XLEN-1]);
                    divisor_d   = magnitude(rs2_data, op_signed && rs2_data[XLEN-1]);
                    rs1_raw_d   = rs1_data;
                    rs2_raw_d   = rs2_data;
                    rem_acc_d   = '0;
                    cnt_d       = '0;
                    state_d     = S_CALC;
`ifdef DIV_FASTPATH_EN
                    // The result does not depend on any iteration, so go straight to DONE.
                    if (fast_special) begin
                        div_out_d = final_result('0, '0, op_signed, op_rem, 1'b0, 1'b0,
                                                 rs1_data, rs2_data);
                        state_d   = S_DONE;
                    end
`endif
                end
            end
            S_CALC: begin
                rem_acc_d = rem_next;
                quo_d     = quo_next;
                cnt_d     = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    div_out_d = final_result(quo_next, rem_next, is_signed_q, is_rem_q,
                                             qsign_q, rsign_q, rs1_raw_q, rs2_raw_q);
                    state_d   = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (flush) begin
            state_d   = S_IDLE;
            div_out_d = div_out_q;
        end
    end

endmodule

// File: tb/tb_divider.sv
// Self-checking bench for divider: directed RV32M cases, randomized operations against an arithmetic model, and control scenarios.
// Latency: expects done 33 cycles after accept, or 1 cycle for special cases when DIV_FASTPATH_EN is defined.
// Backpressure: covers flush mid-operation, reset mid-operation, start in the DONE cycle, and non-divide opcodes.

module tb_divider;
    import m_extension::*;

`ifdef DIV_FASTPATH_EN
    localparam bit FASTPATH = 1'b1;
`else
    localparam bit FASTPATH = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    m_funct3     funct3;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] div_out;

    int errors = 0;
    int checks = 0;

    divider dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .funct3   (funct3),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .flush    (flush),
        .busy     (busy),
        .done     (done),
        .div_out  (div_out)
    );

    always #5 clk = ~clk;

    // Reference results taken from the RV32M definition. Signed division uses plain int arithmetic, which truncates toward zero.
    function automatic logic [31:0] model_result(input m_funct3 f, input logic [31:0] a,
                                                 input logic [31:0] b);
        int sa;
        int sb;
        logic ovf;
        sa  = a;
        sb  = b;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f)
            F3_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            F3_REMU: return (b == 0) ? a : a % b;
            F3_DIV:  begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf)    return 32'h8000_0000;
                return sa / sb;
            end
            F3_REM:  begin
                if (b == 0) return a;
                if (ovf)    return 32'h0;
                return sa % sb;
            end
            default: return 32'h0;
        endcase
    endfunction

    function automatic int model_lat(input m_funct3 f, input logic [31:0] a,
                                     input logic [31:0] b);
        logic special;
        special = (b == 0) ||
                  ((f == F3_DIV || f == F3_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
        return (FASTPATH && special) ? 1 : 33;
    endfunction

    // Issues one operation and waits for done (bounded). lat is the number of falling edges after the accept edge.
    task automatic run_op(input m_funct3 f, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int lat,
                          output logic done_after, output logic busy_after);
        @(negedge clk);
        funct3   = f;
        rs1_data = a;
        rs2_data = b;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat   = 1;
        while (done !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        res = div_out;
        @(negedge clk);
        done_after = done;
        busy_after = busy;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || div_out !== 32'h0) begin
            errors++;
            $display("FAIL reset_state: busy=%b done=%b div_out=%h, required 0 0 00000000",
                     busy, done, div_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: busy=%b done=%b, required 0 0", busy, done);
        end
    endtask

    task automatic test_directed();
        m_funct3     tf[12];
        logic [31:0] ta[12];
        logic [31:0] tb_b[12];
        logic [31:0] te[12];
        logic [31:0] res;
        int          lat;
        logic        d_after;
        logic        b_after;
        tf   = '{F3_DIVU, F3_REMU, F3_DIV, F3_REM, F3_REM, F3_DIVU,
                 F3_REMU, F3_DIV, F3_DIV, F3_REM, F3_DIVU, F3_DIV};
        ta   = '{32'd100, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd7, 32'h1234_5678,
                 32'h1234_5678, 32'hFFFF_FFFB, 32'h8000_0000, 32'h8000_0000,
                 32'hFFFF_FFFF, 32'h8000_0000};
        tb_b = '{32'd7, 32'd7, 32'd2, 32'd2, 32'hFFFF_FFFE, 32'd0,
                 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd2};
        te   = '{32'd14, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF,
                 32'h1234_5678, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0, 32'hFFFF_FFFF,
                 32'hC000_0000};
        for (int i = 0; i < 12; i++) begin
            run_op(tf[i], ta[i], tb_b[i], res, lat, d_after, b_after);
            checks++;
            if (res !== te[i]) begin
                errors++;
                $display("FAIL directed_result[%0d] %s %h/%h: got %h, required %h",
                         i, tf[i].name(), ta[i], tb_b[i], res, te[i]);
            end
            checks++;
            if (lat != model_lat(tf[i], ta[i], tb_b[i])) begin
                errors++;
                $display("FAIL directed_latency[%0d]: got %0d cycles, required %0d",
                         i, lat, model_lat(tf[i], ta[i], tb_b[i]));
            end
            checks++;
            if (d_after !== 1'b0 || b_after !== 1'b0) begin
                errors++;
                $display("FAIL directed_done_pulse[%0d]: after done got done=%b busy=%b, required 0 0",
                         i, d_after, b_after);
            end
        end
    endtask

    task automatic test_random();
        m_funct3     f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        int          lat;
        logic        d_after;
        logic        b_after;
        for (int i = 0; i < 24; i++) begin
            f = m_funct3'(3'(4 + $urandom_range(0, 3)));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 9))
                0: b = 32'h0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = $urandom_range(1, 15);
                3: a = $urandom_range(0, 255);
                4: b = -$urandom_range(1, 15);
                default: ;
            endcase
            run_op(f, a, b, res, lat, d_after, b_after);
            checks++;
            if (res !== model_result(f, a, b)) begin
                errors++;
                $display("FAIL random_result[%0d] %s %h/%h: got %h, required %h",
                         i, f.name(), a, b, res, model_result(f, a, b));
            end
            checks++;
            if (lat != model_lat(f, a, b)) begin
                errors++;
                $display("FAIL random_latency[%0d]: got %0d cycles, required %0d",
                         i, lat, model_lat(f, a, b));
            end
        end
    endtask

    task automatic test_flush();
        logic [31:0] res;
        int          lat;
        logic        d_after;
        logic        b_after;
        int          seen_done;
        run_op(F3_DIVU, 32'd500, 32'd7, res, lat, d_after, b_after);
        checks++;
        if (res !== 32'd71) begin
            errors++;
            $display("FAIL flush_setup: got %h, required %h", res, 32'd71);
        end
        @(negedge clk);
        funct3   = F3_DIVU;
        rs1_data = 32'd1000;
        rs2_data = 32'd3;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL flush_busy_before: busy=%b, required 1", busy);
        end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL flush_to_idle: busy=%b, required 0", busy);
        end
        seen_done = 0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1) seen_done++;
        end
        checks++;
        if (seen_done != 0) begin
            errors++;
            $display("FAIL flush_no_done: saw %0d done cycles, required 0", seen_done);
        end
        checks++;
        if (div_out !== 32'd71) begin
            errors++;
            $display("FAIL flush_div_out_held: got %h, required %h", div_out, 32'd71);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] res;
        int          lat;
        logic        d_after;
        logic        b_after;
        run_op(F3_DIVU, 32'd100, 32'd7, res, lat, d_after, b_after);
        @(negedge clk);
        funct3   = F3_DIVU;
        rs1_data = 32'd12345;
        rs2_data = 32'd11;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if (busy !== 1'b1 || div_out !== 32'd14) begin
            errors++;
            $display("FAIL reset_mid_setup: busy=%b div_out=%h, required 1 %h", busy, div_out, 32'd14);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || div_out !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid_clear: busy=%b done=%b div_out=%h, required 0 0 00000000",
                     busy, done, div_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_op(F3_REMU, 32'd100, 32'd7, res, lat, d_after, b_after);
        checks++;
        if (res !== 32'd2 || lat != 33) begin
            errors++;
            $display("FAIL reset_mid_recover: got %h in %0d cycles, required %h in 33", res, lat, 32'd2);
        end
    endtask

    task automatic test_illegal_op();
        @(negedge clk);
        funct3   = F3_MUL;
        rs1_data = 32'd9;
        rs2_data = 32'd3;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL mul_ignored: busy=%b, required 0", busy);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || div_out !== 32'd2) begin
            errors++;
            $display("FAIL mul_no_effect: busy=%b done=%b div_out=%h, required 0 0 %h",
                     busy, done, div_out, 32'd2);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] res;
        int          lat;
        logic        d_after;
        logic        b_after;
        int          n;
        @(negedge clk);
        funct3   = F3_DIVU;
        rs1_data = 32'd77;
        rs2_data = 32'd7;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 1;
        while (done !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n != 33 || div_out !== 32'd11) begin
            errors++;
            $display("FAIL b2b_first: got %h in %0d cycles, required %h in 33", div_out, n, 32'd11);
        end
        rs1_data = 32'd9;
        rs2_data = 32'd3;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b0 || div_out !== 32'd11) begin
            errors++;
            $display("FAIL start_in_done_ignored: busy=%b div_out=%h, required 0 %h",
                     busy, div_out, 32'd11);
        end
        run_op(F3_DIVU, 32'd9, 32'd3, res, lat, d_after, b_after);
        checks++;
        if (res !== 32'd3 || lat != 33) begin
            errors++;
            $display("FAIL b2b_second: got %h in %0d cycles, required %h in 33", res, lat, 32'd3);
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        flush    = 1'b0;
        funct3   = F3_MUL;
        rs1_data = 32'h0;
        rs2_data = 32'h0;
        test_reset();
        test_directed();
        test_random();
        test_flush();
        test_reset_mid();
        test_illegal_op();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
